// File: rtl/mem_game_pkg.sv
// mem_game_pkg: shared types and constants for the memory-game round controller.
//   - state_t : round controller states
//   - DIG_W   : default bits per pattern digit / key code
//   - KEY_*   : key code constants for the four game keys
package mem_game_pkg;

  localparam int DIG_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_RND = 3'd2,
    SHOW     = 3'd3,
    COLLECT  = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  localparam logic [DIG_W-1:0] KEY_0 = 2'd0;
  localparam logic [DIG_W-1:0] KEY_1 = 2'd1;
  localparam logic [DIG_W-1:0] KEY_2 = 2'd2;
  localparam logic [DIG_W-1:0] KEY_3 = 2'd3;

endpackage

// File: rtl/show_timer.sv
// show_timer: paces pattern replay. Each digit is displayed for SHOW_CYC
// cycles, then a blank gap of SHOW_CYC cycles follows.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   en       : high while the controller is in SHOW; low holds the timer cleared
//   phase    : 0 = digit phase, 1 = blank phase
//   done     : one-cycle pulse in the last cycle of a blank phase
// The cycle counter restarts at 0 on every phase change, so every digit and
// every gap gets the full SHOW_CYC cycles.
module show_timer #(
  parameter int unsigned SHOW_CYC = 24'd12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase,
  output logic done
);

  localparam int CW = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SHOW_CYC - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == LAST);
  assign done = en && phase && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (last) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_round_ctrl.sv
// mem_round_ctrl: game-round controller for a memory (repeat-the-pattern) game.
// Starts the random-delay generator (rnd_go), captures one random digit per
// round when it times out (rnd_to), halts it (rnd_stop), replays the pattern on
// the display, then checks the player's keys.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   start                : player start pulse (IDLE only)
//   rnd_to               : generator timeout pulse (WAIT_RND only)
//   rnd_go, rnd_stop     : one-cycle pulses to the generator
//   key_valid, key_code  : player key pulse and code (COLLECT only)
//   show_valid, show_code: digit being displayed (code 0 when not valid)
//   level                : current pattern length, 0 in IDLE
//   busy                 : high outside IDLE
//   pass, fail           : one-cycle game result pulses
// Build option: define KEY_TIMEOUT_EN to give each key entry TMO_CYC cycles;
// without it COLLECT waits indefinitely and TMO_CYC is unused.
module mem_round_ctrl #(
  parameter int unsigned SEQ_LEN  = 8,
  parameter int unsigned DIG_W    = 2,
  parameter int unsigned SHOW_CYC = 24'd12_500_000,
  parameter int unsigned TMO_CYC  = 28'd250_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rnd_to,
  output logic             rnd_go,
  output logic             rnd_stop,
  input  logic             key_valid,
  input  logic [DIG_W-1:0] key_code,
  output logic             show_valid,
  output logic [DIG_W-1:0] show_code,
  output logic [3:0]       level,
  output logic             busy,
  output logic             pass,
  output logic             fail
);
  import mem_game_pkg::*;

  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  state_t                        state;
  logic [7:0]                    rnd_cnt;
  logic [SEQ_LEN-1:0][DIG_W-1:0] seq;
  logic [IW-1:0]                 idx;
  logic [IW-1:0]                 lvl_idx;
  logic                          show_phase;
  logic                          show_done;
  logic                          tmo_hit;

  // Slot of the newest digit / last digit of the current round.
  assign lvl_idx = IW'(level - 4'd1);

  // Free-running entropy source: the generator's delay is player-dependent,
  // so the count at timeout is effectively random.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rnd_cnt <= '0;
    else      rnd_cnt <= rnd_cnt + 8'd1;
  end

  show_timer #(.SHOW_CYC(SHOW_CYC)) u_show_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (state == SHOW),
    .phase (show_phase),
    .done  (show_done)
  );

`ifdef KEY_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Any key restarts the window; a wrong key leaves COLLECT anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               tmo_cnt <= '0;
    else if (state != COLLECT || key_valid) tmo_cnt <= '0;
    else if (!tmo_hit)                      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign show_valid = (state == SHOW) && !show_phase;
  assign show_code  = show_valid ? seq[idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      level    <= '0;
      idx      <= '0;
      seq      <= '0;
      rnd_go   <= 1'b0;
      rnd_stop <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      rnd_go   <= 1'b0;
      rnd_stop <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          level  <= 4'd1;
          rnd_go <= 1'b1;            // high for the whole ARM cycle
          state  <= ARM;
        end
        ARM: state <= WAIT_RND;
        WAIT_RND: if (rnd_to) begin
          seq[lvl_idx] <= rnd_cnt[DIG_W-1:0];
          rnd_stop     <= 1'b1;
          idx          <= '0;
          state        <= SHOW;
        end
        SHOW: if (show_done) begin
          if (idx == lvl_idx) begin
            idx   <= '0;
            state <= COLLECT;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        COLLECT: begin
          // A key in the expiry cycle takes priority over the timeout.
          if (key_valid) begin
            if (key_code != seq[idx]) begin
              fail     <= 1'b1;
              rnd_stop <= 1'b1;
              state    <= LOSE;
            end else if (idx == lvl_idx) begin
              pass  <= (level == 4'(SEQ_LEN));
              state <= WIN;
            end else begin
              idx   <= idx + 1'b1;
            end
          end else if (tmo_hit) begin
            fail     <= 1'b1;
            rnd_stop <= 1'b1;
            state    <= LOSE;
          end
        end
        WIN: if (level == 4'(SEQ_LEN)) begin
          level <= '0;
          state <= IDLE;
        end else begin
          level  <= level + 4'd1;
          rnd_go <= 1'b1;
          state  <= ARM;
        end
        LOSE: begin
          level <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
